// File: rtl/anc_sample_sched.sv
// Sample scheduler for anc_top: buffers ADC triplets in a small FIFO and issues
// them one at a time, waiting for out_valid or a watchdog before the next one.
module anc_sample_sched #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              adc_strobe,
  input  logic [15:0]       e_adc,
  input  logic [15:0]       x_adc,
  input  logic [15:0]       a_adc,
  input  logic              controller_ready,
  input  logic              out_valid,
  input  logic              clr_err,
  output logic              in_valid,
  output logic [15:0]       e_out,
  output logic [15:0]       x_out,
  output logic [15:0]       a_out,
  output logic              busy,
  output logic [AW:0]       fifo_level,
  output logic [7:0]        overrun_cnt,
  output logic              timeout_err
);

  // Handshake: in_valid is a one-cycle pulse carrying e/x/a; anc_top ends the
  // pass with a one-cycle out_valid, which is honoured only in WAIT.

  // Sized so the counter can hold TIMEOUT+1 on the exit edge without wrapping.
  localparam int WDW = $clog2(TIMEOUT + 2);
  localparam logic [WDW-1:0] TO_W  = WDW'(TIMEOUT);
  localparam logic [AW:0]    FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [47:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    level;
  logic [WDW-1:0] wd_cnt;
  logic           pop;
  logic           push;
  logic           overrun;
  logic           wd_fire;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wd_fire   = 1'b0;
    if (!init_done) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if ((level != '0) && controller_ready) begin
            state_nxt = S_ISSUE;
            pop       = 1'b1;
          end
        end
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          // out_valid wins a tie with the watchdog
          if (out_valid) begin
            state_nxt = S_IDLE;
          end else if (wd_cnt == TO_W) begin
            state_nxt = S_IDLE;
            wd_fire   = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign push    = init_done && adc_strobe && ((level != FULL) || pop);
  assign overrun = init_done && adc_strobe && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (!init_done) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {e_adc, x_adc, a_adc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid <= 1'b0;
      e_out    <= '0;
      x_out    <= '0;
      a_out    <= '0;
    end else begin
      in_valid <= pop;
      if (pop) {e_out, x_out, a_out} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Error bookkeeping survives init_done low; clr_err beats a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else if (clr_err) begin
      overrun_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (overrun && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end

  assign fifo_level = level;

endmodule

// File: doc/anc_sample_sched.md
# anc_sample_sched

Sample scheduler in front of `anc_top`. It captures (e, x, a) sample triplets from the ADC front-end into a small FIFO and dispatches them one at a time using the `in_valid`/`controller_ready` handshake. Only one sample is in flight at a time: the next is not dispatched until the FIR returns `out_valid` or a watchdog expires. It also counts dropped samples, flags stalled FIR passes, and reports FIFO occupancy to the host register block.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in triplets; power of two, at least 2.
- `AW`, 2: log2(DEPTH).
- `TIMEOUT`, 1023: maximum cycles in WAIT before the watchdog fires.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  in  1  system initialised; low means flush and hold.
- `adc_strobe`  in  1  one-cycle pulse; a new triplet is present on the ADC inputs.
- `e_adc`, `x_adc`, `a_adc`  in  16 each  signed error, reference and desired samples.
- `controller_ready`  in  1  `anc_top` can accept a sample.
- `out_valid`  in  1  `anc_top` output pulse; ends the in-flight pass.
- `clr_err`  in  1  one-cycle pulse; clears `overrun_cnt` and `timeout_err`.
- `in_valid`  out  1  registered one-cycle dispatch pulse to `anc_top`.
- `e_out`, `x_out`, `a_out`  out  16 each  registered triplet; valid while `in_valid` is high, held afterwards.
- `busy`  out  1  high in the ISSUE and WAIT states.
- `fifo_level`  out  AW+1  current FIFO occupancy, 0 to DEPTH.
- `overrun_cnt`  out  8  count of dropped strobes; saturates at 255.
- `timeout_err`  out  1  sticky flag; set when the watchdog fires.

## Operation
Reset values:
- All outputs are 0.
- FIFO is empty.
- FSM is in IDLE.
- Watchdog counter is 0.

FIFO:
- Circular buffer with separate read and write pointers and an occupancy counter.
- Pointers wrap modulo DEPTH.
- A push happens on `adc_strobe` when `fifo_level < DEPTH`, or when a pop occurs in the same cycle.
- A strobe that cannot be pushed is dropped and increments `overrun_cnt`, saturating at 255.
- When push and pop happen in the same cycle, the level is unchanged and both pointers advance.

FSM:
- IDLE → ISSUE when `init_done` is high, `fifo_level` ≠ 0 and `controller_ready` is high.
  - On this edge, the FIFO head is loaded into `e_out`/`x_out`/`a_out`, the head is popped and `in_valid` is set to 1.
- ISSUE → WAIT unconditionally after one cycle.
  - `in_valid` returns to 0.
  - The watchdog counter is cleared to 0.
- WAIT → IDLE when `out_valid` is high.
- WAIT → IDLE when the watchdog counter equals TIMEOUT.
  - Sets `timeout_err`; the in-flight sample is abandoned.
- If `out_valid` and the timeout occur in the same cycle, `out_valid` wins and `timeout_err` is not set.
- In WAIT the watchdog counter increments every cycle (11-bit counter for the default TIMEOUT).
- `out_valid` seen in IDLE or ISSUE is ignored.

`init_done` low:
- Takes effect synchronously from any state: FSM goes to IDLE, FIFO is flushed (pointers and level to 0), `in_valid` goes to 0.
- Strobes arriving while `init_done` is low are discarded and do not count as overruns.
- `overrun_cnt` and `timeout_err` are kept.

`clr_err`:
- Clears `overrun_cnt` and `timeout_err`.
- If it coincides with a new overrun or timeout, the clear takes priority.

Asynchronous reset in the middle of a pass returns every register to its reset value immediately. No outstanding pass is tracked afterwards.

## Timing
- Dispatch latency: a strobe sampled at edge k into an empty FIFO, with the FSM in IDLE and `controller_ready` high, gives `in_valid` high during the cycle following edge k+1 (2 cycles).
- `fifo_level` reflects a push or pop the cycle after the edge that performs it.
- `in_valid` is high for exactly 1 cycle per dispatch and is never asserted in two consecutive cycles.
- Minimum spacing between dispatches is 3 cycles: ISSUE, then WAIT with `out_valid` arriving in its first cycle, then IDLE.
- Timeout path: ISSUE, then TIMEOUT+1 cycles in WAIT, then IDLE. `timeout_err` is visible the cycle after the WAIT exit edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Single sample:** reset, `init_done`=1, `controller_ready`=1, one strobe with e=0x0100, x=0xFF00, a=0x0010.
  - `in_valid` pulses 2 cycles later carrying those values.
  - `busy` stays high until `out_valid` is pulsed 20 cycles later.
  - `fifo_level` reads 1, then 0.
- **Overrun:** hold `out_valid` low with TIMEOUT=1023 and issue 6 strobes 1 cycle apart.
  - First strobe is dispatched; 4 are queued (`fifo_level`=4).
  - `overrun_cnt`=1.
  - `clr_err` returns it to 0.
- **Watchdog:** TIMEOUT=15 and `out_valid` never pulsed.
  - FSM leaves WAIT 16 cycles after ISSUE.
  - `timeout_err`=1.
  - Next queued sample is dispatched.
  - Pulsing `out_valid` in the exact expiry cycle instead leaves `timeout_err`=0.
- **Full FIFO push with pop:** FIFO full and a strobe arrives in the IDLE→ISSUE edge cycle.
  - Push is accepted, `fifo_level` stays at 4, `overrun_cnt` is unchanged.
  - Data order is preserved across the pointer wrap.
- **Flush and reset:** drop `init_done` with 3 samples queued in WAIT.
  - Next cycle: `fifo_level`=0, `busy`=0.
  - Strobes while `init_done`=0 leave level and `overrun_cnt` unchanged.
  - Asserting `rst_n`=0 in the middle of WAIT zeroes all outputs without waiting for a clock edge.
- **Backpressure:** queue 2 samples with `controller_ready`=0 for 10 cycles.
  - No `in_valid` pulse occurs.
  - Raising `controller_ready` dispatches both in order, each waiting for its own `out_valid`.
